// File: rtl/pixel_pkg.sv
// Shared types, widths and the pixel-to-intensity reduction for pixel_window_fetch.
// PIXEL_LUMA_EN selects (R+2G+B)>>2 intensity; otherwise the green channel is used.
package pixel_pkg;

   localparam int unsigned WIN_PIX = 9;
   localparam int unsigned PIX_W   = 8;
   localparam int unsigned WIN_W   = WIN_PIX * PIX_W;
   localparam int unsigned COORD_W = 16;
   localparam int unsigned DATA_W  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [PIX_W-1:0] r;
      logic [PIX_W-1:0] g;
      logic [PIX_W-1:0] b;
   } rgb_t;

   // 10-bit sum cannot overflow, so the >>2 result always fits in 8 bits
   function automatic logic [PIX_W-1:0] luma(input rgb_t px);
`ifdef PIXEL_LUMA_EN
      logic [9:0] sum;
      sum = 10'(px.r) + 10'({px.g, 1'b0}) + 10'(px.b);
      return sum[9:2];
`else
      logic unused_rb;
      unused_rb = ^{px.r, px.b};
      return px.g;
`endif
   endfunction

endpackage

// File: rtl/pixel_window_fetch_if.sv
// Memory read bus plus window valid/ready stream of pixel_window_fetch.
interface pixel_window_fetch_if #(
   parameter int unsigned ADDR_W = 32
);
   import pixel_pkg::*;

   logic [DATA_W-1:0]  hrdata;
   logic               hready;
   logic [ADDR_W-1:0]  haddr;
   logic               hreq;
   logic               hwrite;
   logic [WIN_W-1:0]   win_data;
   logic [COORD_W-1:0] win_x;
   logic [COORD_W-1:0] win_y;
   logic               win_valid;
   logic               win_ready;

   modport master (
      input  hrdata, hready, win_ready,
      output haddr, hreq, hwrite, win_data, win_x, win_y, win_valid
   );

   modport slave (
      output hrdata, hready, win_ready,
      input  haddr, hreq, hwrite, win_data, win_x, win_y, win_valid
   );

endinterface

// File: rtl/pixel_line_buffer.sv
// Two line buffers (rows y-2 and y-1) indexed by x; read-before-write shifts a column per pixel.
module pixel_line_buffer
   import pixel_pkg::*;
#(
   parameter int unsigned DEPTH = 428,
   parameter int unsigned AW    = 9
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] wdata,
   output logic [PIX_W-1:0] rd_far_c,
   output logic [PIX_W-1:0] rd_near_c
);

   logic [PIX_W-1:0] row_far_q  [DEPTH];
   logic [PIX_W-1:0] row_near_q [DEPTH];

   assign rd_far_c  = row_far_q[addr];
   assign rd_near_c = row_near_q[addr];

   // Contents need no reset: every row is rewritten before it is read into a window
   always_ff @(posedge clk) begin
      if (we) begin
         row_far_q[addr]  <= row_near_q[addr];
         row_near_q[addr] <= wdata;
      end
   end

endmodule

// File: rtl/pixel_window_fetch.sv
// Raster-scan read master emitting one 3x3 intensity neighbourhood per interior pixel.
// Build option: PIXEL_LUMA_EN (luma intensity instead of green channel, see pixel_pkg).
module pixel_window_fetch
   import pixel_pkg::*;
#(
   parameter int unsigned       IMG_WIDTH  = 428,
   parameter int unsigned       IMG_HEIGHT = 428,
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    start,
   input  logic                    stop,
   pixel_window_fetch_if.master    bus,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

   if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_size
      $error("pixel_window_fetch: IMG_WIDTH and IMG_HEIGHT must be >= 3");
   end

   fetch_state_t                   state_q, state_d;
   logic [COORD_W-1:0]             x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0]             win_x_q, win_x_d, win_y_q, win_y_d;
   logic [ADDR_W-1:0]              haddr_q, haddr_d;
   logic [2:0][2:0][PIX_W-1:0]     win_q, win_d;
   logic                           last_q, last_d;
   logic                           hreq_q, hreq_d, win_valid_q, win_valid_d;
   logic                           busy_q, busy_d, done_q, done_d;

   logic                           cap_c;
   logic [PIX_W-1:0]               pix_c, far_c, near_c;
   logic [7:0]                     unused_pad;

   assign cap_c      = (state_q == REQ) && bus.hready;
   assign pix_c      = luma(rgb_t'(bus.hrdata[31:8]));
   assign unused_pad = bus.hrdata[7:0];

   pixel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(AW)) u_line_buffer (
      .clk       (clk),
      .we        (cap_c),
      .addr      (AW'(x_q)),
      .wdata     (pix_c),
      .rd_far_c  (far_c),
      .rd_near_c (near_c)
   );

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      win_x_d = win_x_q;
      win_y_d = win_y_q;
      haddr_d = haddr_q;
      win_d   = win_q;
      last_d  = last_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = REQ;
               x_d     = '0;
               y_d     = '0;
               haddr_d = BASE_ADDR;
            end
         end
         REQ: begin
            if (bus.hready) begin
               // Column shift; a new row starts from a cleared window
               for (int r = 0; r < 3; r++) begin
                  win_d[r][2] = (x_q == '0) ? '0 : win_q[r][1];
                  win_d[r][1] = (x_q == '0) ? '0 : win_q[r][0];
               end
               win_d[2][0] = far_c;
               win_d[1][0] = near_c;
               win_d[0][0] = pix_c;
               win_x_d = x_q - 16'd1;
               win_y_d = y_q - 16'd1;
               last_d  = (x_q == 16'(IMG_WIDTH - 1)) && (y_q == 16'(IMG_HEIGHT - 1));
               haddr_d = haddr_q + ADDR_W'(1);
               if (x_q == 16'(IMG_WIDTH - 1)) begin
                  x_d = '0;
                  y_d = y_q + 16'd1;
               end else begin
                  x_d = x_q + 16'd1;
               end
               if (x_q >= 16'd2 && y_q >= 16'd2) begin
                  state_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (bus.win_ready) begin
               state_d = last_q ? DONE : REQ;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase

      if (stop) begin
         state_d = IDLE;
      end

      hreq_d      = (state_d == REQ);
      win_valid_d = (state_d == EMIT);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         win_x_q     <= '0;
         win_y_q     <= '0;
         haddr_q     <= BASE_ADDR;
         win_q       <= '0;
         last_q      <= 1'b0;
         hreq_q      <= 1'b0;
         win_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         win_x_q     <= win_x_d;
         win_y_q     <= win_y_d;
         haddr_q     <= haddr_d;
         win_q       <= win_d;
         last_q      <= last_d;
         hreq_q      <= hreq_d;
         win_valid_q <= win_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.haddr     = haddr_q;
   assign bus.hreq      = hreq_q;
   assign bus.hwrite    = 1'b0;
   assign bus.win_data  = win_q;
   assign bus.win_x     = win_x_q;
   assign bus.win_y     = win_y_q;
   assign bus.win_valid = win_valid_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_pixel_window_fetch.sv
// Directed bench: a 3x3 instance and a 5x4 instance at word address 64, zero-wait memory models.
`timescale 1ns/1ps
module tb_pixel_window_fetch;
   import pixel_pkg::*;

   localparam logic [31:0] B5 = 32'd64;
`ifdef PIXEL_LUMA_EN
   localparam logic [7:0] RB_P = 8'd127;
`else
   localparam logic [7:0] RB_P = 8'd0;
`endif

   logic clk = 1'b0;
   logic n_rst, start3, stop3, start5, stop5;
   logic busy3, done3, busy5, done5;
   logic rgb_mode, hready5_en;
   logic [7:0] v3, v5;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pixel_window_fetch_if #(.ADDR_W(32)) bus3 ();
   pixel_window_fetch_if #(.ADDR_W(32)) bus5 ();

   // Memory models: 3x3 image holds 10*index, 5x4 image holds 7*index+3, all channels equal
   assign v3          = 8'(bus3.haddr * 32'd10);
   assign bus3.hrdata = rgb_mode ? 32'hFF00_FF00 : {v3, v3, v3, 8'h00};
   assign bus3.hready = 1'b1;
   assign v5          = 8'((bus5.haddr - B5) * 32'd7 + 32'd3);
   assign bus5.hrdata = {v5, v5, v5, 8'h00};
   assign bus5.hready = hready5_en;

   pixel_window_fetch #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .ADDR_W(32), .BASE_ADDR(32'd0)) dut3 (
      .clk(clk), .n_rst(n_rst), .start(start3), .stop(stop3), .bus(bus3.master),
      .busy(busy3), .done(done3));

   pixel_window_fetch #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .ADDR_W(32), .BASE_ADDR(B5)) dut5 (
      .clk(clk), .n_rst(n_rst), .start(start5), .stop(stop5), .bus(bus5.master),
      .busy(busy5), .done(done5));

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] val5(input int i);
      return 8'(i * 7 + 3);
   endfunction

   function automatic logic [71:0] exp_win5(input int k);
      logic [71:0] d;
      int cx, cy;
      d  = '0;
      cx = 1 + k % 3;
      cy = 1 + k / 3;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            d = {d[63:0], val5((cy - 1 + r) * 5 + (cx - 1 + c))};
      return d;
   endfunction

   task automatic run3(output int n, output int nwin, output logic [71:0] wd,
                       output logic [15:0] wx, output logic [15:0] wy);
      n = 0; nwin = 0; wd = '0; wx = '0; wy = '0;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      while (!done3 && n < 40) begin
         if (bus3.win_valid) begin
            nwin++;
            wd = bus3.win_data;
            wx = bus3.win_x;
            wy = bus3.win_y;
         end
         tick();
         n++;
      end
   endtask

   task automatic wait_addr5(input logic [31:0] a, input string tag);
      int n;
      n = 0;
      while (!(bus5.hreq && bus5.haddr == a) && n < 100) begin
         tick();
         n++;
      end
      chk(tag, 72'(bus5.haddr), 72'(a));
   endtask

   initial begin
      int n, nwin, k;
      logic [71:0] wd, exp3;
      logic [15:0] wx, wy;
      logic [31:0] maxaddr;

      n_rst = 1'b0; start3 = 1'b0; stop3 = 1'b0; start5 = 1'b0; stop5 = 1'b0;
      rgb_mode = 1'b0; hready5_en = 1'b1;
      bus3.win_ready = 1'b1; bus5.win_ready = 1'b1;
      repeat (2) tick();

      chk("rst_haddr",     72'(bus5.haddr), 72'(B5));
      chk("rst_haddr3",    72'(bus3.haddr), 72'd0);
      chk("rst_hreq",      72'(bus5.hreq), 72'd0);
      chk("rst_hwrite",    72'(bus5.hwrite), 72'd0);
      chk("rst_win_valid", 72'(bus5.win_valid), 72'd0);
      chk("rst_win_data",  bus5.win_data, 72'd0);
      chk("rst_win_xy",    72'({bus5.win_x, bus5.win_y}), 72'd0);
      chk("rst_busy_done", 72'({busy5, done5}), 72'd0);
      n_rst = 1'b1;
      tick();

      // 3x3 frame: single window centred at (1,1)
      exp3 = '0;
      for (int i = 0; i < 9; i++) exp3 = {exp3[63:0], 8'(i * 10)};
      run3(n, nwin, wd, wx, wy);
      chk("f3_latency",  72'(n), 72'd10);
      chk("f3_nwin",     72'(nwin), 72'd1);
      chk("f3_win_data", wd, exp3);
      chk("f3_win_xy",   72'({wx, wy}), 72'({16'd1, 16'd1}));
      tick();
      chk("f3_done_pulse", 72'({done3, busy3}), 72'd0);

      // RGB reduction of {255,0,255}
      rgb_mode = 1'b1;
      run3(n, nwin, wd, wx, wy);
      chk("rgb_nwin", 72'(nwin), 72'd1);
      chk("rgb_win",  wd, {9{RB_P}});
      rgb_mode = 1'b0;
      tick();

      // 5x4 frame with a read stall on pixel (2,2) and consumer backpressure
      start5 = 1'b1;
      tick();
      start5 = 1'b0;
      chk("f5_first", 72'({bus5.hreq, bus5.haddr}), 72'({1'b1, B5}));
      wait_addr5(B5 + 32'd12, "f5_reach_22");
      hready5_en = 1'b0;
      bus5.win_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_bus", 72'({bus5.hreq, bus5.haddr}), 72'({1'b1, B5 + 32'd12}));
         chk("stall_no_win", 72'(bus5.win_valid), 72'd0);
      end
      hready5_en = 1'b1;
      tick();
      chk("w0_valid", 72'(bus5.win_valid), 72'd1);
      for (int i = 0; i < 4; i++) begin
         chk("hold_data", bus5.win_data, exp_win5(0));
         chk("hold_xy",   72'({bus5.win_valid, bus5.win_x, bus5.win_y}), 72'({1'b1, 16'd1, 16'd1}));
         chk("hold_bus",  72'({bus5.hreq, bus5.haddr}), 72'({1'b0, B5 + 32'd13}));
         tick();
      end
      bus5.win_ready = 1'b1;
      k = 1; n = 0; maxaddr = B5 + 32'd13;
      while (!done5 && n < 200) begin
         tick();
         n++;
         if (bus5.hreq && bus5.haddr > maxaddr) maxaddr = bus5.haddr;
         if (bus5.win_valid) begin
            chk("f5_win_data", bus5.win_data, exp_win5(k));
            chk("f5_win_xy", 72'({bus5.win_x, bus5.win_y}), 72'({16'(1 + k % 3), 16'(1 + k / 3)}));
            k++;
         end
      end
      chk("f5_done",     72'(done5), 72'd1);
      chk("f5_nwin",     72'(k), 72'd6);
      chk("f5_max_addr", 72'(maxaddr), 72'(B5 + 32'd19));
      tick();

      // start while busy ignored, then stop+start together aborts
      start5 = 1'b1;
      tick();
      start5 = 1'b0;
      wait_addr5(B5 + 32'd3, "ab_reach_3");
      start5 = 1'b1;
      tick();
      start5 = 1'b0;
      chk("busy_start_ignored", 72'({busy5, bus5.haddr}), 72'({1'b1, B5 + 32'd4}));
      wait_addr5(B5 + 32'd11, "ab_reach_11");
      stop5 = 1'b1;
      start5 = 1'b1;
      tick();
      stop5 = 1'b0;
      start5 = 1'b0;
      chk("stop_idle", 72'({busy5, bus5.hreq, bus5.win_valid}), 72'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stop_no_done", 72'({done5, busy5, bus5.hreq}), 72'd0);
      end
      start5 = 1'b1;
      tick();
      start5 = 1'b0;
      chk("restart_first", 72'({bus5.hreq, bus5.haddr}), 72'({1'b1, B5}));
      n = 0;
      while (!bus5.win_valid && n < 100) begin
         tick();
         n++;
      end
      chk("restart_w0_data", bus5.win_data, exp_win5(0));
      chk("restart_w0_xy", 72'({bus5.win_valid, bus5.win_x, bus5.win_y}), 72'({1'b1, 16'd1, 16'd1}));
      n = 0;
      while (!done5 && n < 200) begin
         tick();
         n++;
      end
      chk("restart_done", 72'(done5), 72'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pixel_window_fetch.md
# pixel_window_fetch

Parametrised raster-scan read master for the edge-detection datapath. Reads a W×H RGB image from word-addressed memory over the hready bus handshake, reduces each pixel to an 8-bit intensity, holds two line buffers plus a 3×3 register window, and emits one 3×3 neighbourhood per interior pixel through a valid/ready port. It sits between image memory and the Sobel/threshold stage, replacing fixed-size fetch logic with width/height/base-address parameters, backpressure and abort.

## Interface
- IMG_WIDTH, 428, pixels per row, must be ≥3 (elaboration error otherwise)
- IMG_HEIGHT, 428, rows, must be ≥3
- ADDR_W, 32, haddr width
- BASE_ADDR, 0, word address of pixel (0,0); pixel (x,y) at BASE_ADDR + y*IMG_WIDTH + x
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse, begins a frame from IDLE
- stop  in  1  abort; returns to IDLE next edge
- hrdata  in  32  read data, {R,G,B,8'h00}, valid when hready=1
- hready  in  1  slave completes the current read
- haddr  out  ADDR_W  read address
- hreq  out  1  read request outstanding
- hwrite  out  1  constant 0 (read-only master, keeps bus port set uniform)
- win_data  out  72  3×3 window, row-major, [71:64]=top-left … [7:0]=bottom-right
- win_x, win_y  out  16 each  centre coordinates of win_data
- win_valid  out  1  window available
- win_ready  in  1  consumer accepts window
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse after last window accepted

## Operation
- States: IDLE, REQ, EMIT, DONE.
- IDLE: hreq=0; start → REQ with x=y=0.
- REQ: hreq=1, haddr = BASE_ADDR + y*IMG_WIDTH + x. On edge with hready=1: capture pixel, convert to intensity p, shift p into window column, write p into line buffer, advance x (wrap to 0 and y+1 at x=IMG_WIDTH-1). If x≥2 and y≥2 → EMIT, else stay REQ (or DONE if last pixel, impossible for W,H≥3 without EMIT).
- EMIT: win_valid=1, win_x=x-1, win_y=y-1 of captured pixel; window holds rows y-2..y, cols x-2..x. On win_valid&&win_ready: if captured pixel was (W-1,H-1) → DONE, else → REQ.
- DONE: done=1 for one cycle → IDLE.
- Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame, in raster order of centre.
- Window register cleared at start of each row (x=0) so no cross-row contamination.
- stop in any state → IDLE next edge; done not pulsed; win_valid drops; buffers not cleared (next frame overwrites).
- start while busy ignored. stop and start same cycle: stop wins.
- hready while hreq=0 ignored.
- Intensity rule: 10-bit sum, truncated >>2; never saturates.

## Timing
- Reset (n_rst=0 at edge): state IDLE, haddr=BASE_ADDR, hreq=0, hwrite=0, win_valid=0, win_data=0, win_x=win_y=0, busy=0, done=0.
- Address stable while hreq=1 until hready sampled high; next address driven cycle after capture.
- Zero-wait memory, no backpressure: non-emitting pixel 1 cycle; emitting pixel 2 cycles (REQ+EMIT).
- win_valid asserts the cycle after capture; win_data/win_x/win_y stable while win_valid && !win_ready.
- done asserts the cycle after the final handshake; start → first hreq: 1 cycle.

## Configuration
- PIXEL_LUMA_EN defined: p = (R + 2G + B) >> 2.
- Undefined: p = G (hrdata[23:16]); adders removed. Window format and timing identical.

## Structure
- pixel_pkg: state enum fetch_state_t, rgb_t packed struct {r,g,b}, WIN_PIX=9, PIX_W=8, luma function (guarded by PIXEL_LUMA_EN).
- Sub-module pixel_line_buffer: two IMG_WIDTH×8 rows, indexed by x, read both rows and write current pixel same cycle (read-before-write); top-level instantiates one.

## Test plan
- 3×3 image, values R=G=B=10*(index), win_ready=1 → one window centre (1,1), win_data = 0,10,…,80 row-major, done one cycle after, total 10 cycles start→done.
- 428×428 frame, zero-wait memory → 426*426=181476 windows, last win_x=win_y=426, haddr range BASE_ADDR..BASE_ADDR+183183.
- hready held low 5 cycles on pixel (2,2) → haddr/hreq stable 5 cycles, window emitted only after hready.
- win_ready low 4 cycles on first window → win_data/win_x/win_y unchanged, no new haddr issued.
- stop pulsed mid-row 10 → IDLE next cycle, hreq=0, no done; new start restarts at BASE_ADDR with correct first window.
- Pixel {R=255,G=0,B=255}: with PIXEL_LUMA_EN p=127, without p=0.
